// File: rtl/wptr_full.sv
// Write-domain pointer and full/level logic for the async FIFO.
// Keeps a binary write pointer, publishes it Gray-coded, and derives full, almost-full, level and overflow.
module wptr_full #(
  parameter int addr_size          = 3,
  parameter int almost_full_margin = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 winc,
  input  logic [addr_size:0]   wq2_rptr,
  input  logic                 ovf_clr,
  output logic [addr_size-1:0] waddr,
  output logic [addr_size:0]   wptr,
  output logic                 wfull,
  output logic                 w_almost_full,
  output logic [addr_size:0]   wlevel,
  output logic                 woverflow
);

  localparam int PW = addr_size + 1;
  localparam logic [PW-1:0] DEPTH     = {1'b1, {addr_size{1'b0}}};
  localparam logic [PW-1:0] AF_THRESH = DEPTH - PW'(almost_full_margin);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_ptr;
  logic          accept;

  assign accept     = winc & ~wfull;
  assign wbin_next  = wbin + {{addr_size{1'b0}}, accept};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Gray-to-binary: each bit is the XOR of itself and every bit above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Full when the write pointer has lapped the read pointer by exactly one depth.
  assign full_ptr   = {~wq2_rptr[addr_size:addr_size-1], wq2_rptr[addr_size-2:0]};
  assign level_next = wbin_next - rbin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin          <= '0;
      wptr          <= '0;
      wfull         <= 1'b0;
      w_almost_full <= 1'b0;
      wlevel        <= '0;
      woverflow     <= 1'b0;
    end else begin
      wbin          <= wbin_next;
      wptr          <= wgray_next;
      wfull         <= (wgray_next == full_ptr);
      w_almost_full <= (level_next >= AF_THRESH);
      wlevel        <= level_next;
      if (winc & wfull) begin
        woverflow <= 1'b1;
      end else if (ovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

  assign waddr = wbin[addr_size-1:0];

endmodule
